// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the arithmetic-unit command sequencer.
// The command struct is what travels through the FIFO and onto the unit.
package alu_seq_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 3;
    localparam int FLAG_W   = 5;

    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // A watchdog abort reports an invalid operation with no result.
    localparam logic [FLAG_W-1:0] TMO_FLAGS = FLAG_W'(1) << FLG_INVALID;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } seq_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   op_a;
        logic [DATA_W-1:0]   op_b;
        logic [OPCODE_W-1:0] op_code;
        logic                mode_fp;
        logic                round_mode;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Registered-output-free command FIFO: head entry is read combinationally.
// Full/empty derive from a registered occupancy count.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the arithmetic unit: queues commands, runs one at a time,
// captures the response with a watchdog and keeps sticky exception flags.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [DATA_W-1:0]          CMD_OP_A,
    input  logic [DATA_W-1:0]          CMD_OP_B,
    input  logic [OPCODE_W-1:0]        CMD_OP_CODE,
    input  logic                       CMD_MODE_FP,
    input  logic                       CMD_ROUND_MODE,
    output logic [DATA_W-1:0]          ALU_OP_A,
    output logic [DATA_W-1:0]          ALU_OP_B,
    output logic [OPCODE_W-1:0]        ALU_OP_CODE,
    output logic                       ALU_MODE_FP,
    output logic                       ALU_ROUND_MODE,
    output logic                       ALU_START,
    input  logic [DATA_W-1:0]          ALU_RESULT,
    input  logic                       ALU_VALID,
    input  logic [FLAG_W-1:0]          ALU_FLAGS,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [DATA_W-1:0]          RSP_RESULT,
    output logic [FLAG_W-1:0]          RSP_FLAGS,
    output logic                       RSP_TIMEOUT,
    output logic [FLAG_W-1:0]          STICKY_FLAGS,
    input  logic                       CLR_FLAGS,
    output logic                       BUSY,
    output logic [$clog2(DEPTH+1)-1:0] CMD_COUNT
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seq_state_t           state_q, state_d;
    alu_cmd_t             cmd_q, cmd_d;
    alu_cmd_t             cmd_in;
    logic                 alu_start_q, alu_start_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]    rsp_flags_q, rsp_flags_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [FLAG_W-1:0]    sticky_q, sticky_d;
    logic                 rsp_load;

    logic                 fifo_pop;
    logic [CMD_W-1:0]     fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    always_comb begin
        cmd_in            = '0;
        cmd_in.op_a       = CMD_OP_A;
        cmd_in.op_b       = CMD_OP_B;
        cmd_in.op_code    = CMD_OP_CODE;
        cmd_in.mode_fp    = CMD_MODE_FP;
        cmd_in.round_mode = CMD_ROUND_MODE;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (CMD_VALID),
        .wdata (cmd_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        alu_start_d   = 1'b0;
        tmo_cnt_d     = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_load      = 1'b0;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_rdata;
                    alu_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A real result beats a watchdog expiry in the same cycle.
                if (ALU_VALID) begin
                    rsp_load      = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = ALU_RESULT;
                    rsp_flags_d   = ALU_FLAGS;
                    rsp_timeout_d = 1'b0;
                    state_d       = HOLD;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT-1)) begin
                    rsp_load      = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = '0;
                    rsp_flags_d   = TMO_FLAGS;
                    rsp_timeout_d = 1'b1;
                    state_d       = HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (rsp_valid_q && RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear applies before the new capture is folded in.
        sticky_d = CLR_FLAGS ? '0 : sticky_q;
        if (rsp_load) sticky_d = sticky_d | rsp_flags_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            alu_start_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
            sticky_q      <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            alu_start_q   <= alu_start_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_timeout_q <= rsp_timeout_d;
            sticky_q      <= sticky_d;
        end
    end

    assign CMD_READY      = !fifo_full;
    assign CMD_COUNT      = fifo_count;
    assign BUSY           = (state_q != IDLE) || !fifo_empty;
    assign ALU_OP_A       = cmd_q.op_a;
    assign ALU_OP_B       = cmd_q.op_b;
    assign ALU_OP_CODE    = cmd_q.op_code;
    assign ALU_MODE_FP    = cmd_q.mode_fp;
    assign ALU_ROUND_MODE = cmd_q.round_mode;
    assign ALU_START      = alu_start_q;
    assign RSP_VALID      = rsp_valid_q;
    assign RSP_RESULT     = rsp_result_q;
    assign RSP_FLAGS      = rsp_flags_q;
    assign RSP_TIMEOUT    = rsp_timeout_q;
    assign STICKY_FLAGS   = sticky_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small latency-based unit model.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int MDL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic        cmd_fp = 1'b0;
    logic        cmd_rnd = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        clr_flags = 1'b0;
    logic [31:0] alu_result;
    logic        alu_valid;
    logic [4:0]  alu_flags;

    logic        CMD_READY;
    logic [31:0] ALU_OP_A, ALU_OP_B, RSP_RESULT;
    logic [2:0]  ALU_OP_CODE;
    logic        ALU_MODE_FP, ALU_ROUND_MODE, ALU_START;
    logic        RSP_VALID, RSP_TIMEOUT, BUSY;
    logic [4:0]  RSP_FLAGS, STICKY_FLAGS;
    logic [2:0]  CMD_COUNT;

    int n_chk = 0;
    int n_err = 0;

    logic        mdl_en = 1'b1;
    logic [31:0] mdl_fp_res = '0;
    logic [4:0]  mdl_flags = '0;
    int          kick_req = 0;
    int          kick_ack = 0;
    logic        mdl_pend;
    int          mdl_cnt;
    logic [31:0] m_a, m_b;
    logic        m_fp;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
        .CLK            (clk),
        .RESET          (rst),
        .CMD_VALID      (cmd_valid),
        .CMD_READY      (CMD_READY),
        .CMD_OP_A       (cmd_a),
        .CMD_OP_B       (cmd_b),
        .CMD_OP_CODE    (cmd_op),
        .CMD_MODE_FP    (cmd_fp),
        .CMD_ROUND_MODE (cmd_rnd),
        .ALU_OP_A       (ALU_OP_A),
        .ALU_OP_B       (ALU_OP_B),
        .ALU_OP_CODE    (ALU_OP_CODE),
        .ALU_MODE_FP    (ALU_MODE_FP),
        .ALU_ROUND_MODE (ALU_ROUND_MODE),
        .ALU_START      (ALU_START),
        .ALU_RESULT     (alu_result),
        .ALU_VALID      (alu_valid),
        .ALU_FLAGS      (alu_flags),
        .RSP_VALID      (RSP_VALID),
        .RSP_READY      (rsp_ready),
        .RSP_RESULT     (RSP_RESULT),
        .RSP_FLAGS      (RSP_FLAGS),
        .RSP_TIMEOUT    (RSP_TIMEOUT),
        .STICKY_FLAGS   (STICKY_FLAGS),
        .CLR_FLAGS      (clr_flags),
        .BUSY           (BUSY),
        .CMD_COUNT      (CMD_COUNT)
    );

    // Unit model: VALID pulses MDL_LAT enabled cycles after START.
    initial begin
        alu_valid  = 1'b0;
        alu_result = '0;
        alu_flags  = '0;
        mdl_pend   = 1'b0;
        mdl_cnt    = 0;
        m_a = '0; m_b = '0; m_fp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            alu_valid = 1'b0;
            if (kick_ack != kick_req) begin
                kick_ack   = kick_req;
                alu_valid  = 1'b1;
                alu_result = 32'hDEADBEEF;
                alu_flags  = 5'b11111;
                mdl_pend   = 1'b0;
            end else if (mdl_pend && mdl_en) begin
                if (mdl_cnt == MDL_LAT-1) begin
                    alu_valid  = 1'b1;
                    alu_result = m_fp ? mdl_fp_res : m_a + m_b;
                    alu_flags  = mdl_flags;
                    mdl_pend   = 1'b0;
                end else begin
                    mdl_cnt++;
                end
            end
            if (ALU_START) begin
                mdl_pend = 1'b1;
                mdl_cnt  = 0;
                m_a  = ALU_OP_A;
                m_b  = ALU_OP_B;
                m_fp = ALU_MODE_FP;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic fp);
        int w;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_fp = fp;
        cmd_valid = 1'b1;
        w = 0;
        while (!CMD_READY && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", 32'(CMD_READY), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output logic ok);
        int w;
        ok = 1'b0;
        w = 0;
        while (!ok && w < budget) begin
            @(negedge clk);
            w++;
            if (RSP_VALID) ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        logic ok;
        int   fs, ns, rv, s, r, bad, st, nv;
        logic [31:0] res;
        logic [4:0]  flg;
        logic [31:0] exp_res [5];
        exp_res = '{32'h111, 32'h112, 32'h113, 32'h114, 32'h115};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  32'(CMD_READY), 32'd1);
        chk("rst_start",  32'(ALU_START), 32'd0);
        chk("rst_rspv",   32'(RSP_VALID), 32'd0);
        chk("rst_busy",   32'(BUSY), 32'd0);
        chk("rst_count",  32'(CMD_COUNT), 32'd0);
        chk("rst_sticky", 32'(STICKY_FLAGS), 32'd0);
        chk("rst_opa",    ALU_OP_A, 32'd0);
        rst = 1'b0;

        // Single FP op with start/response latency
        rsp_ready = 1'b1;
        mdl_fp_res = 32'h40400000;
        mdl_flags = 5'b00000;
        push(32'h3F800000, 32'h40000000, 3'd0, 1'b1);
        fs = 0; ns = 0; rv = 0;
        for (int i = 1; i <= 20 && rv == 0; i++) begin
            @(negedge clk);
            if (ALU_START) begin
                ns++;
                if (fs == 0) fs = i;
            end
            if (RSP_VALID) rv = i;
        end
        chk("t1_start_at",  fs, 32'd2);
        chk("t1_start_len", ns, 32'd1);
        chk("t1_rsp_at",    rv, 32'd6);
        chk("t1_result",    RSP_RESULT, 32'h40400000);
        chk("t1_flags",     32'(RSP_FLAGS), 32'd0);
        chk("t1_tmo",       32'(RSP_TIMEOUT), 32'd0);
        chk("t1_opa",       ALU_OP_A, 32'h3F800000);
        chk("t1_fp",        32'(ALU_MODE_FP), 32'd1);

        // Back-pressure with a stalled unit
        mdl_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(32'h11 + 32'(k), 32'h100, 3'd1, 1'b0);
        end
        @(negedge clk);
        chk("t2_count", 32'(CMD_COUNT), 32'd4);
        chk("t2_ready", 32'(CMD_READY), 32'd0);
        chk("t2_busy",  32'(BUSY), 32'd1);
        mdl_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(100, ok);
            chk("t2_rsp_seen", 32'(ok), 32'd1);
            chk("t2_result", RSP_RESULT, exp_res[k]);
        end

        // Response held by consumer back-pressure
        @(negedge clk);
        rsp_ready = 1'b0;
        mdl_flags = 5'b00010;
        push(32'd5, 32'd7, 3'd2, 1'b0);
        push(32'd1, 32'd2, 3'd3, 1'b0);
        wait_rsp(50, ok);
        chk("t3_rsp_seen", 32'(ok), 32'd1);
        res = RSP_RESULT;
        flg = RSP_FLAGS;
        chk("t3_result", res, 32'd12);
        chk("t3_opcode", 32'(ALU_OP_CODE), 32'd2);
        bad = 0; st = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!RSP_VALID || RSP_RESULT !== res || RSP_FLAGS !== flg) bad++;
            if (ALU_START) st++;
        end
        chk("t3_stable",   bad, 32'd0);
        chk("t3_no_start", st, 32'd0);
        chk("t3_queued",   32'(CMD_COUNT), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_rsp(50, ok);
        chk("t3_rsp2_seen", 32'(ok), 32'd1);
        chk("t3_result2",   RSP_RESULT, 32'd3);
        chk("t3_opcode2",   32'(ALU_OP_CODE), 32'd3);

        // Sticky flags
        @(negedge clk);
        clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        @(negedge clk);
        chk("t4_clear", 32'(STICKY_FLAGS), 32'd0);
        mdl_flags = 5'b00001;
        push(32'd1, 32'd1, 3'd0, 1'b0);
        wait_rsp(50, ok);
        mdl_flags = 5'b00100;
        push(32'd2, 32'd1, 3'd0, 1'b0);
        wait_rsp(50, ok);
        chk("t4_sticky_or", 32'(STICKY_FLAGS), 32'h05);
        mdl_flags = 5'b01000;
        push(32'd2, 32'd2, 3'd0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (alu_valid) begin
                ok = 1'b1;
                clr_flags = 1'b1;
                @(posedge clk);
                #1 clr_flags = 1'b0;
            end
        end
        chk("t4_valid_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("t4_rspv",       32'(RSP_VALID), 32'd1);
        chk("t4_rsp_flags",  32'(RSP_FLAGS), 32'h08);
        chk("t4_sticky_clr", 32'(STICKY_FLAGS), 32'h08);

        // Watchdog timeout, stale VALID, then normal issue
        @(negedge clk);
        mdl_en = 1'b0;
        rsp_ready = 1'b0;
        push(32'd3, 32'd4, 3'd0, 1'b0);
        s = 0; r = 0;
        for (int i = 1; i <= 120 && r == 0; i++) begin
            @(negedge clk);
            if (ALU_START) s = i;
            if (RSP_VALID) r = i;
        end
        chk("t5_latency", r - s, 32'd65);
        chk("t5_tmo",     32'(RSP_TIMEOUT), 32'd1);
        chk("t5_flags",   32'(RSP_FLAGS), 32'h10);
        chk("t5_result",  RSP_RESULT, 32'd0);
        chk("t5_sticky",  32'(STICKY_FLAGS), 32'h18);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(negedge clk);
        kick_req++;
        nv = 0; st = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (RSP_VALID) nv++;
            if (ALU_START) st++;
        end
        chk("t5_stale_rsp",   nv, 32'd0);
        chk("t5_stale_start", st, 32'd0);
        chk("t5_idle",        32'(BUSY), 32'd0);
        mdl_en = 1'b1;
        push(32'd10, 32'd20, 3'd0, 1'b0);
        wait_rsp(50, ok);
        chk("t5_next_seen", 32'(ok), 32'd1);
        chk("t5_next_res",  RSP_RESULT, 32'd30);
        chk("t5_next_tmo",  32'(RSP_TIMEOUT), 32'd0);

        // Reset while waiting with two queued commands
        @(negedge clk);
        mdl_en = 1'b0;
        push(32'd1, 32'd1, 3'd0, 1'b0);
        push(32'd2, 32'd2, 3'd0, 1'b0);
        push(32'd3, 32'd3, 3'd0, 1'b0);
        @(negedge clk);
        chk("t6_pre_count", 32'(CMD_COUNT), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_ready",  32'(CMD_READY), 32'd1);
        chk("t6_count",  32'(CMD_COUNT), 32'd0);
        chk("t6_busy",   32'(BUSY), 32'd0);
        chk("t6_start",  32'(ALU_START), 32'd0);
        chk("t6_rspv",   32'(RSP_VALID), 32'd0);
        chk("t6_result", RSP_RESULT, 32'd0);
        chk("t6_flags",  32'(RSP_FLAGS), 32'd0);
        chk("t6_tmo",    32'(RSP_TIMEOUT), 32'd0);
        chk("t6_sticky", 32'(STICKY_FLAGS), 32'd0);
        chk("t6_opa",    ALU_OP_A, 32'd0);
        mdl_en = 1'b1;
        nv = 0; st = 0; ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (alu_valid) ok = 1'b1;
            if (RSP_VALID) nv++;
            if (ALU_START) st++;
        end
        chk("t6_unit_fired", 32'(ok), 32'd1);
        chk("t6_no_rsp",     nv, 32'd0);
        chk("t6_no_start",   st, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
